// File: rtl/wm_actuator_driver_if.sv
// Signal bundle between the washing-machine stage controller and the actuator driver.
// The controller side drives stage/supply; the driver side drives every actuator line.
interface wm_actuator_driver_if;
   logic [2:0] stage;
   logic       supply;
   logic       water_valve;
   logic       motor_en;
   logic       motor_dir;
   logic       motor_fast;
   logic       drain_pump;
   logic       door_lock;
   logic       buzzer;
   logic       fault;

   modport master (
      output stage, supply,
      input  water_valve, motor_en, motor_dir, motor_fast,
             drain_pump, door_lock, buzzer, fault
   );

   modport slave (
      input  stage, supply,
      output water_valve, motor_en, motor_dir, motor_fast,
             drain_pump, door_lock, buzzer, fault
   );
endinterface

// File: rtl/wm_actuator_driver.sv
// Washing-machine actuator driver: maps the stage code onto registered actuator outputs,
// with drum agitation, spin-down door-lock hold-off, a timed buzzer and a sticky illegal-stage fault.
module wm_actuator_driver #(
   parameter int AGIT_PERIOD  = 2,
   parameter int UNLOCK_DELAY = 3,
   parameter int BUZZ_TIME    = 3,
   parameter int CNT_W        = 8
) (
   input logic                  clk,
   input logic                  rst,
   wm_actuator_driver_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_WASH  = 3'd2,
      ST_RINSE = 3'd3,
      ST_SPIN  = 3'd4,
      ST_DONE  = 3'd5
   } stage_e;

   localparam logic [CNT_W-1:0] AGIT_LAST   = CNT_W'(AGIT_PERIOD - 1);
   localparam logic [CNT_W-1:0] UNLOCK_LOAD = CNT_W'(UNLOCK_DELAY);
   localparam logic [CNT_W-1:0] BUZZ_LOAD   = CNT_W'(BUZZ_TIME);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic [2:0]       prev_stage_q, prev_stage_d;
   logic [CNT_W-1:0] agit_cnt_q, agit_cnt_d;
   logic [CNT_W-1:0] unlock_cnt_q, unlock_cnt_d;
   logic [CNT_W-1:0] buzz_cnt_q, buzz_cnt_d;
   logic             dir_q, dir_d;
   logic             lock_q, lock_d;
   logic             fault_q, fault_d;
   logic             valve_q, valve_d;
   logic             motor_en_q, motor_en_d;
   logic             fast_q, fast_d;
   logic             pump_q, pump_d;
   logic             buzz_q, buzz_d;
   logic             entry, in_lock, was_lock;

   // A power cut leaves every piece of state frozen and only drops the powered actuators.
   always_comb begin
      prev_stage_d = prev_stage_q;
      agit_cnt_d   = agit_cnt_q;
      unlock_cnt_d = unlock_cnt_q;
      buzz_cnt_d   = buzz_cnt_q;
      dir_d        = dir_q;
      lock_d       = lock_q;
      fault_d      = fault_q;
      valve_d      = 1'b0;
      motor_en_d   = 1'b0;
      fast_d       = 1'b0;
      pump_d       = 1'b0;
      buzz_d       = 1'b0;
      entry        = 1'b0;
      in_lock      = 1'b0;
      was_lock     = 1'b0;

      if (bus.supply) begin
         entry        = (bus.stage != prev_stage_q);
         in_lock      = (bus.stage >= ST_FILL) && (bus.stage <= ST_SPIN);
         was_lock     = (prev_stage_q >= ST_FILL) && (prev_stage_q <= ST_SPIN);
         prev_stage_d = bus.stage;
         if (bus.stage > ST_DONE)
            fault_d = 1'b1;

         if (in_lock) begin
            lock_d       = 1'b1;
            unlock_cnt_d = '0;
         end else if (was_lock) begin
            unlock_cnt_d = UNLOCK_LOAD;
            lock_d       = (UNLOCK_LOAD != '0);
         end else if (unlock_cnt_q != '0) begin
            unlock_cnt_d = unlock_cnt_q - CNT_ONE;
            lock_d       = (unlock_cnt_q != CNT_ONE);
         end else begin
            lock_d = 1'b0;
         end

         if ((bus.stage == ST_DONE) && entry)
            buzz_cnt_d = BUZZ_LOAD;
         else if (buzz_cnt_q != '0)
            buzz_cnt_d = buzz_cnt_q - CNT_ONE;

         // Agitation: hold each direction for AGIT_PERIOD cycles, restarting on every wash/rinse entry.
         if ((bus.stage == ST_WASH) || (bus.stage == ST_RINSE)) begin
            if (entry) begin
               agit_cnt_d = '0;
               dir_d      = 1'b0;
            end else if (agit_cnt_q == AGIT_LAST) begin
               agit_cnt_d = '0;
               dir_d      = ~dir_q;
            end else begin
               agit_cnt_d = agit_cnt_q + CNT_ONE;
            end
         end else begin
            agit_cnt_d = '0;
            dir_d      = 1'b0;
         end

         if (fault_d) begin
            agit_cnt_d = '0;
            dir_d      = 1'b0;
         end else begin
            case (bus.stage)
               ST_FILL:  valve_d = 1'b1;
               ST_WASH:  motor_en_d = 1'b1;
               ST_RINSE: begin
                  valve_d    = 1'b1;
                  motor_en_d = 1'b1;
               end
               ST_SPIN:  begin
                  motor_en_d = 1'b1;
                  fast_d     = 1'b1;
                  pump_d     = 1'b1;
               end
               default:  ;
            endcase
            buzz_d = (buzz_cnt_d != '0);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_stage_q <= ST_IDLE;
         agit_cnt_q   <= '0;
         unlock_cnt_q <= '0;
         buzz_cnt_q   <= '0;
         dir_q        <= 1'b0;
         lock_q       <= 1'b0;
         fault_q      <= 1'b0;
         valve_q      <= 1'b0;
         motor_en_q   <= 1'b0;
         fast_q       <= 1'b0;
         pump_q       <= 1'b0;
         buzz_q       <= 1'b0;
      end else begin
         prev_stage_q <= prev_stage_d;
         agit_cnt_q   <= agit_cnt_d;
         unlock_cnt_q <= unlock_cnt_d;
         buzz_cnt_q   <= buzz_cnt_d;
         dir_q        <= dir_d;
         lock_q       <= lock_d;
         fault_q      <= fault_d;
         valve_q      <= valve_d;
         motor_en_q   <= motor_en_d;
         fast_q       <= fast_d;
         pump_q       <= pump_d;
         buzz_q       <= buzz_d;
      end
   end

   assign bus.water_valve = valve_q;
   assign bus.motor_en    = motor_en_q;
   assign bus.motor_dir   = dir_q;
   assign bus.motor_fast  = fast_q;
   assign bus.drain_pump  = pump_q;
   assign bus.door_lock   = lock_q;
   assign bus.buzzer      = buzz_q;
   assign bus.fault       = fault_q;

endmodule
